hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the in-order core. It sits beside the decode stage and owns a per-register scoreboard of in-flight writes, which it uses to generate the decode stall for RAW hazards and memory back-pressure. It also squashes decode after a taken redirect from AGEX and latches a sticky halt on an invalid opcode. Fetch and decode are its only consumers; it never touches datapath values.

## Interface
- `MAX_INFLIGHT`, 3: maximum outstanding writes tracked per register; sets the counter width to clog2(MAX_INFLIGHT+1).
- `FLUSH_CYCLES`, 2: number of cycles decode is squashed, counting the redirect cycle itself; legal range 1..7.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `decode_valid` in 1: the decode slot holds an instruction.
- `decode_inst_op` in `INST_OP_WIDTH`: decoded instruction class.
- `decode_rs1_num`, `decode_rs2_num` in 5 each: source registers; 0 means unused.
- `decode_drnum` in 5: destination register.
- `decode_reg_we` in 1: the instruction writes `decode_drnum`.
- `agex_redirect` in 1: a taken branch or jump resolved in AGEX this cycle.
- `mem_busy` in 1: the memory stage cannot accept a new instruction.
- `wb_valid`, `wb_reg_we` in 1 each: a writeback is retiring this cycle.
- `wb_drnum` in 5: writeback destination register.
- `decode_stall` out 1: hold the decode and fetch registers.
- `decode_flush` out 1: kill the decode slot, so nothing is issued.
- `halted` out 1: sticky; an invalid instruction was issued.
- `pending_mask` out 32: bit r is set when cnt[r] != 0; bit 0 is always 0.

## Operation
- Scoreboard: `cnt[1..31]`, one counter per register. Register 0 is never tracked.
- issue = decode_valid & ~decode_stall & ~decode_flush & ~halted.
- Increment condition: issue & decode_reg_we & decode_drnum != 0.
- Decrement condition: wb_valid & wb_reg_we & wb_drnum != 0.
- Increment and decrement of the same register in the same cycle leaves the count unchanged.
- raw = decode_valid & ((rs1 != 0 & cnt[rs1] != 0) | (rs2 != 0 & cnt[rs2] != 0)).
- No writeback bypass. A source is released the cycle after its final decrement.
- sat = decode_valid & decode_reg_we & decode_drnum != 0 & cnt[decode_drnum] == MAX_INFLIGHT.
- decode_stall = ~decode_flush & (mem_busy | raw | sat | halted).
- FSM states:
  - RUN → FLUSH on agex_redirect, loading flush_cnt = FLUSH_CYCLES-1. If FLUSH_CYCLES = 1, stay in RUN.
  - FLUSH: flush_cnt decrements each cycle; → RUN when it reaches 0. A new agex_redirect reloads the counter.
  - RUN → HALT on issue & decode_inst_op == INST_OP_INVALID.
  - HALT is absorbing until reset. Writebacks still decrement the scoreboard.
- decode_flush = agex_redirect | (state == FLUSH). Flush wins over stall and over halt detection.
- A decrement on a zero counter is an assertion failure; the counter saturates at 0.
- An increment on a full counter cannot occur because sat stalls decode.

## Timing
- decode_stall, decode_flush and pending_mask are combinational from registered state plus same-cycle inputs. There are no registered paths to them.
- Scoreboard and FSM update on the rising clk edge.
- Hazard latency: consumer issue is the cycle after writeback of the last pending write.
- Reset (asynchronous, any time, including mid-flush or halted):
  - all counters = 0, state = RUN, flush_cnt = 0, halted = 0.
  - decode_flush = 0 and pending_mask = 0 on the following cycle, unless inputs assert.
  - decode_stall = mem_busy.
- Simultaneous mem_busy and redirect: flush = 1 and stall = 0.

## Structure
- Add to the shared constants package: `HC_STATE_RUN`, `HC_STATE_FLUSH`, `HC_STATE_HALT` (2-bit state encoding).
- Reuse the existing `INST_OP_*` constants.
- One sub-module: `reg_scoreboard`. It holds the 31 counters with an inc/dec port pair, two lookup ports for the sources, a full-check port for the destination, and the mask output.
- The FSM and stall logic stay in `hazard_ctrl`.

## Test plan
- RAW: issue a write to x5; next cycle decode reads rs1=5 → stall=1. wb x5 at cycle 4 → stall still 1 at cycle 4, stall=0 and issue at cycle 5.
- x0: issue writes to x0 while decode reads rs1=0 → never stalls; pending_mask stays 0.
- Same-cycle inc/dec: cnt[7]=1, then issue write x7 plus wb x7 in the same cycle → cnt[7]=1 and pending_mask[7]=1. A second wb → bit clears.
- Saturation: 3 issued writes to x9 with no wb, then a 4th writer of x9 → stall=1 until one wb.
- Redirect with FLUSH_CYCLES=2, with mem_busy=1 and a RAW hazard present:
  - flush=1 for exactly 2 cycles with stall=0.
  - No scoreboard change.
  - An INVALID opcode in the flushed slot does not halt.
- Halt and reset:
  - An INVALID op issues → halted=1 and stall=1 indefinitely.
  - rst_n pulsed low mid-halt → halted=0, mask=0, state RUN.
  - Normal issue resumes the next cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the decode-side sequencing logic: instruction classes
// and the hazard controller's state encoding.
package hazard_ctrl_pkg;

  localparam int INST_OP_WIDTH = 4;

  localparam logic [INST_OP_WIDTH-1:0] INST_OP_ALU     = 4'd0;
  localparam logic [INST_OP_WIDTH-1:0] INST_OP_LOAD    = 4'd1;
  localparam logic [INST_OP_WIDTH-1:0] INST_OP_STORE   = 4'd2;
  localparam logic [INST_OP_WIDTH-1:0] INST_OP_BRANCH  = 4'd3;
  localparam logic [INST_OP_WIDTH-1:0] INST_OP_JUMP    = 4'd4;
  localparam logic [INST_OP_WIDTH-1:0] INST_OP_INVALID = 4'hF;

  localparam logic [1:0] HC_STATE_RUN   = 2'd0;
  localparam logic [1:0] HC_STATE_FLUSH = 2'd1;
  localparam logic [1:0] HC_STATE_HALT  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register in-flight write counters (x1..x31) with source lookups,
// destination full check and a pending mask. x0 is never tracked.
module reg_scoreboard #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic [4:0]  inc_num,
  input  logic        dec_en,
  input  logic [4:0]  dec_num,
  input  logic [4:0]  rs1_num,
  input  logic [4:0]  rs2_num,
  input  logic [4:0]  chk_num,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        chk_full,
  output logic [31:0] pending_mask
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_INFLIGHT);

  logic [31:0] full_vec;

  assign pending_mask[0] = 1'b0;
  assign full_vec[0]     = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      logic          inc_hit;
      logic          dec_hit;

      assign inc_hit = inc_en && (inc_num == 5'(gi));
      assign dec_hit = dec_en && (dec_num == 5'(gi));

      // A simultaneous inc and dec cancel; a stray dec at zero holds at zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (inc_hit && !dec_hit) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end else if (dec_hit && !inc_hit && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - CNT_ONE;
        end
      end

      assign pending_mask[gi] = (cnt_reg != '0);
      assign full_vec[gi]     = (cnt_reg == CNT_FULL);

      a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec_hit && !inc_hit && cnt_reg == '0));
    end
  endgenerate

  assign rs1_busy = pending_mask[rs1_num];
  assign rs2_busy = pending_mask[rs2_num];
  assign chk_full = full_vec[chk_num];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode sequencing: RAW/saturation/memory stalls from the register
// scoreboard, redirect squash window and sticky halt on invalid issue.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     decode_valid,
  input  logic [INST_OP_WIDTH-1:0] decode_inst_op,
  input  logic [4:0]               decode_rs1_num,
  input  logic [4:0]               decode_rs2_num,
  input  logic [4:0]               decode_drnum,
  input  logic                     decode_reg_we,
  input  logic                     agex_redirect,
  input  logic                     mem_busy,
  input  logic                     wb_valid,
  input  logic                     wb_reg_we,
  input  logic [4:0]               wb_drnum,
  output logic                     decode_stall,
  output logic                     decode_flush,
  output logic                     halted,
  output logic [31:0]              pending_mask
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state_reg, state_next;
  logic [2:0] flush_cnt_reg, flush_cnt_next;
  logic       rs1_busy, rs2_busy, dst_full;
  logic       raw, sat, issue, inc_en, dec_en;

  assign halted       = (state_reg == HC_STATE_HALT);
  assign decode_flush = agex_redirect || (state_reg == HC_STATE_FLUSH);
  assign raw          = decode_valid && (rs1_busy || rs2_busy);
  assign sat          = decode_valid && decode_reg_we && (decode_drnum != 5'd0) && dst_full;
  assign decode_stall = !decode_flush && (mem_busy || raw || sat || halted);
  assign issue        = decode_valid && !decode_stall && !decode_flush && !halted;
  assign inc_en       = issue && decode_reg_we && (decode_drnum != 5'd0);
  assign dec_en       = wb_valid && wb_reg_we && (wb_drnum != 5'd0);

  reg_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_en       (inc_en),
    .inc_num      (decode_drnum),
    .dec_en       (dec_en),
    .dec_num      (wb_drnum),
    .rs1_num      (decode_rs1_num),
    .rs2_num      (decode_rs2_num),
    .chk_num      (decode_drnum),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .chk_full     (dst_full),
    .pending_mask (pending_mask)
  );

  // The redirect cycle itself is the first squashed cycle, so the
  // counter only covers the remaining FLUSH_CYCLES-1.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      HC_STATE_RUN: begin
        if (agex_redirect) begin
          if (FLUSH_CYCLES > 1) begin
            state_next     = HC_STATE_FLUSH;
            flush_cnt_next = FLUSH_LOAD;
          end
        end else if (issue && decode_inst_op == INST_OP_INVALID) begin
          state_next = HC_STATE_HALT;
        end
      end
      HC_STATE_FLUSH: begin
        if (agex_redirect) begin
          flush_cnt_next = FLUSH_LOAD;
        end else if (flush_cnt_reg <= 3'd1) begin
          state_next     = HC_STATE_RUN;
          flush_cnt_next = 3'd0;
        end else begin
          flush_cnt_next = flush_cnt_reg - 3'd1;
        end
      end
      HC_STATE_HALT: ;
      default: begin
        state_next     = HC_STATE_RUN;
        flush_cnt_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HC_STATE_RUN;
      flush_cnt_reg <= 3'd0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

endmodule
